xor_stream_descrambler: RTL and testbench

- Serial self-synchronising descrambler. It is the receive-side inverse of the team's XOR-based scrambler, polynomial x^7 + x^6 + 1 by default.
- It accepts one scrambled bit per valid/ready handshake and recovers the original data bit.
- It sits between the line-side bit deserialiser and the frame parser.
- Datapath XOR/AND/NOR logic is built from the team's gate primitives and powered through DigitSupply.

---
 rtl/xor_stream_descrambler.sv | 154 +++++++++++++++
 tb/tb_xor_stream_descrambler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/xor_stream_descrambler.sv
// Serial self-synchronising descrambler for x^7 + x^6 + 1 (the inverse of the team XOR scrambler).
// Latency: one clock from accept to outValid. The first LFSR_WIDTH accepts after reset or Flush only fill the history.
// Backpressure: single output register; inReady = !outValid || outReady, and Flush forces inReady low.
// Optional feature: define DESCRAMBLER_BYPASS_EN to add the Bypass input (pass-through, history keeps tracking).

// Two-input XOR gate primitive, fed from the distributed supply rails.
module dsc_xor2 (
    input  logic [1:0] supply,
    input  logic       a,
    input  logic       b,
    output logic       y
);
    logic unused_supply;
    assign unused_supply = ^supply;
    assign y = a ^ b;
endmodule

// Two-input AND gate primitive, fed from the distributed supply rails.
module dsc_and2 (
    input  logic [1:0] supply,
    input  logic       a,
    input  logic       b,
    output logic       y
);
    logic unused_supply;
    assign unused_supply = ^supply;
    assign y = a & b;
endmodule

// Two-input NOR gate primitive, fed from the distributed supply rails.
module dsc_nor2 (
    input  logic [1:0] supply,
    input  logic       a,
    input  logic       b,
    output logic       y
);
    logic unused_supply;
    assign unused_supply = ^supply;
    assign y = ~(a | b);
endmodule

module xor_stream_descrambler #(
    parameter int LFSR_WIDTH = 7,
    parameter int TAP_A      = 6,
    parameter int TAP_B      = 7
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] DigitSupply,
    input  logic       Flush,
    input  logic       inData,
    input  logic       inValid,
    output logic       inReady,
    output logic       outData,
    output logic       outValid,
    input  logic       outReady,
`ifdef DESCRAMBLER_BYPASS_EN
    input  logic       Bypass,
`endif
    output logic       locked
);
    localparam int CNT_W = $clog2(LFSR_WIDTH + 1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      fill_cnt_q, fill_cnt_d;
    logic [LFSR_WIDTH:1]   sr_q, sr_d;
    logic                  out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    logic bypass_on;
    logic stall;
    logic ready_raw;
    logic accept;
    logic tap_xor;
    logic descr_bit;

`ifdef DESCRAMBLER_BYPASS_EN
    assign bypass_on = Bypass;
`else
    assign bypass_on = 1'b0;
`endif

    // Output register is busy when it holds a bit that downstream is not taking.
    assign stall = out_valid_q & ~outReady;

    // Ready unless stalled or flushing: NOR of the two blocking conditions.
    dsc_nor2 u_ready (.supply(DigitSupply), .a(stall), .b(Flush), .y(ready_raw));
    dsc_and2 u_accept (.supply(DigitSupply), .a(inValid), .b(ready_raw), .y(accept));

    // Descrambled bit uses the history as it stood before this accept's shift.
    dsc_xor2 u_tap   (.supply(DigitSupply), .a(sr_q[TAP_A]), .b(sr_q[TAP_B]), .y(tap_xor));
    dsc_xor2 u_descr (.supply(DigitSupply), .a(inData), .b(tap_xor), .y(descr_bit));

    // Next-state: Flush dominates; otherwise drain on outReady and load on accept.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        sr_d        = sr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (Flush) begin
            state_d     = FILL;
            fill_cnt_d  = '0;
            sr_d        = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && outReady) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                sr_d = {sr_q[LFSR_WIDTH-1:1], inData};
                if (fill_cnt_q != CNT_W'(LFSR_WIDTH)) begin
                    fill_cnt_d = fill_cnt_q + CNT_W'(1);
                end
                if (state_q == FILL && fill_cnt_q == CNT_W'(LFSR_WIDTH - 1)) begin
                    state_d = RUN;
                end
                // The final fill accept still lands in FILL, so it produces no output.
                if (state_q == RUN || bypass_on) begin
                    out_data_d  = bypass_on ? inData : descr_bit;
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    // State and datapath registers; reset clears any pending output at once.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            sr_q        <= '0;
            out_data_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            sr_q        <= sr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign inReady  = ready_raw;
    assign outData  = out_data_q;
    assign outValid = out_valid_q;
    assign locked   = (state_q == RUN);

endmodule

// File: tb/tb_xor_stream_descrambler.sv
module tb_xor_stream_descrambler;
    logic       Clock = 1'b0;
    logic       Reset;
    logic [1:0] DigitSupply = 2'b10;
    logic       Flush;
    logic       inData;
    logic       inValid;
    logic       inReady;
    logic       outData;
    logic       outValid;
    logic       outReady;
    logic       locked;
`ifdef DESCRAMBLER_BYPASS_EN
    logic       Bypass;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    xor_stream_descrambler dut (
        .Clock(Clock),
        .Reset(Reset),
        .DigitSupply(DigitSupply),
        .Flush(Flush),
        .inData(inData),
        .inValid(inValid),
        .inReady(inReady),
        .outData(outData),
        .outValid(outValid),
        .outReady(outReady),
`ifdef DESCRAMBLER_BYPASS_EN
        .Bypass(Bypass),
`endif
        .locked(locked)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Offer one bit with outReady high; sample #1 after the accepting edge.
    task automatic send(input logic b);
        @(negedge Clock);
        inData  = b;
        inValid = 1'b1;
        outReady = 1'b1;
        @(posedge Clock);
        #1;
        inValid = 1'b0;
    endtask

    initial begin : stim
        logic [7:0]  imp_in;
        logic [7:0]  imp_exp;
        logic [5:0]  bp_exp;
        logic [63:0] src;
        logic [6:0]  scr;
        logic        s;

        Reset = 1'b1; Flush = 1'b0; inData = 1'b0; inValid = 1'b0; outReady = 1'b1;
`ifdef DESCRAMBLER_BYPASS_EN
        Bypass = 1'b0;
`endif
        #12;
        chk("rst_outValid", outValid, 1'b0);
        chk("rst_outData",  outData,  1'b0);
        chk("rst_locked",   locked,   1'b0);
        chk("rst_inReady",  inReady,  1'b1);
        @(negedge Clock);
        Reset = 1'b0;

        // Fill with seven zeros.
        for (int i = 0; i < 7; i++) begin
            send(1'b0);
            chk("fill_outValid", outValid, 1'b0);
            chk("fill_locked", locked, (i == 6) ? 1'b1 : 1'b0);
        end

        // Impulse response 1,0,0,0,0,0,0,0 -> 1,0,0,0,0,0,1,1.
        imp_in  = 8'b1000_0000;
        imp_exp = 8'b1000_0011;
        for (int i = 7; i >= 0; i--) begin
            send(imp_in[i]);
            chk("imp_outValid", outValid, 1'b1);
            chk("imp_outData",  outData,  imp_exp[i]);
        end

        // Backpressure: a 1 is emitted, then held for three stalled cycles.
        send(1'b1);
        chk("bp_first", outData, 1'b1);
        @(negedge Clock);
        outReady = 1'b0; inValid = 1'b1; inData = 1'b0;
        repeat (3) begin
            @(posedge Clock);
            #1;
            chk("bp_inReady",  inReady,  1'b0);
            chk("bp_outValid", outValid, 1'b1);
            chk("bp_outData",  outData,  1'b1);
        end
        @(negedge Clock);
        outReady = 1'b1;
        #1;
        chk("bp_release_ready", inReady, 1'b1);
        @(posedge Clock);
        #1;
        inValid = 1'b0;
        chk("bp_release_vld", outValid, 1'b1);
        chk("bp_release_dat", outData,  1'b0);
        // The single 1 must reappear exactly at taps 6 and 7.
        bp_exp = 6'b000011;
        for (int i = 5; i >= 0; i--) begin
            send(1'b0);
            chk("bp_seq", outData, bp_exp[i]);
        end

        // Flush colliding with a valid bit in RUN.
        @(negedge Clock);
        Flush = 1'b1; inValid = 1'b1; inData = 1'b1;
        #1;
        chk("fl_inReady", inReady, 1'b0);
        @(posedge Clock);
        #1;
        Flush = 1'b0; inValid = 1'b0;
        chk("fl_outValid", outValid, 1'b0);
        chk("fl_locked",   locked,   1'b0);

        // Round trip through a scrambler model; the first 7 bits refill.
        src = {$urandom, $urandom};
        src[63] = 1'b1;
        scr = 7'h5A;
        for (int i = 0; i < 64; i++) begin
            s = src[i] ^ scr[5] ^ scr[6];
            scr = {scr[5:0], s};
            send(s);
            if (i < 7) begin
                chk("rt_fill_vld", outValid, 1'b0);
                chk("rt_locked", locked, (i == 6) ? 1'b1 : 1'b0);
            end else begin
                chk("rt_vld", outValid, 1'b1);
                chk("rt_dat", outData,  src[i]);
            end
        end

        // Asynchronous reset mid-stream with a pending 1 on the output.
        @(negedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_outValid", outValid, 1'b0);
        chk("arst_outData",  outData,  1'b0);
        chk("arst_locked",   locked,   1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(1'b1);
            chk("refill_vld", outValid, 1'b0);
            chk("refill_locked", locked, (i == 6) ? 1'b1 : 1'b0);
        end
        send(1'b1);
        chk("refill_first_vld", outValid, 1'b1);
        chk("refill_first_dat", outData,  1'b1);

`ifdef DESCRAMBLER_BYPASS_EN
        // Bypass from reset: 1,0,1,0,0,1,1,0 pass straight through.
        @(negedge Clock);
        Reset = 1'b1; Bypass = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        imp_in = 8'b1010_0110;
        for (int i = 7; i >= 0; i--) begin
            send(imp_in[i]);
            chk("byp_vld", outValid, 1'b1);
            chk("byp_dat", outData,  imp_in[i]);
        end
        chk("byp_locked", locked, 1'b1);
        // History: taps 6 and 7 hold 1 and 0, so a 0 descrambles to 1.
        Bypass = 1'b0;
        send(1'b0);
        chk("byp_exit_vld", outValid, 1'b1);
        chk("byp_exit_dat", outData,  1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
